// File: rtl/mem_access_unit.sv
// Load/store unit between a pipeline request port and a word-wide data memory.
// Sub-word loads are extracted and extended; sub-word stores go through a read-modify-write.

module mau_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  offs,
  input  logic [15:0] wdata,
  input  logic [7:0]  old_byte,
  output logic [7:0]  new_byte
);
  localparam logic [1:0] L = 2'(LANE);

  // LANE is the big-endian byte number, so lane 0 holds bits [31:24]
  always_comb begin
    new_byte = old_byte;
    if (size == 2'b00 && offs == L)
      new_byte = wdata[7:0];
    else if (size == 2'b01 && offs[1] == L[1])
      new_byte = L[0] ? wdata[7:0] : wdata[15:8];
  end
endmodule

module mem_access_unit #(
  parameter int MEM_WORDS = 1000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req_valid,
  output logic        Req_ready,
  input  logic        Req_write,
  input  logic [1:0]  Req_size,
  input  logic        Req_signed,
  input  logic [31:0] Req_addr,
  input  logic [31:0] Req_wdata,
  output logic        Resp_valid,
  output logic [31:0] Resp_rdata,
  output logic        Resp_err,
  output logic [31:0] Mem_address,
  output logic [31:0] Mem_write_data,
  output logic        Mem_read,
  output logic        Mem_write,
  input  logic [31:0] Mem_read_data
);
  localparam int NUM_LANES = 4;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10;

  typedef enum logic [2:0] {IDLE, RD, RD_DONE, RMW_MERGE, WR, RESP_ERR} state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q;
  logic [31:0] wword_q;
  logic        accept, req_err;
  logic        resp_vld_nxt, resp_err_nxt;
  logic [31:0] rdata_nxt, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [NUM_LANES-1:0][7:0] rd_lanes, mrg_lanes;

  assign Req_ready = (state == IDLE);
  assign accept    = Req_ready && Req_valid;
  assign req_err   = (Req_size == 2'b11)
                  || (Req_size == SZ_H && Req_addr[0])
                  || (Req_size == SZ_W && Req_addr[1:0] != 2'b00)
                  || ({2'b00, Req_addr[31:2]} >= 32'(MEM_WORDS));

  // Memory strobes depend on registered state only
  assign Mem_read       = (state == RD);
  assign Mem_write      = (state == WR);
  assign Mem_address    = (state == RD || state == WR) ? {2'b00, req_q.addr[31:2]} : '0;
  assign Mem_write_data = (state == WR) ? wword_q : '0;

  assign rd_lanes = Mem_read_data;

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      mau_lane #(.LANE(NUM_LANES-1-g)) u_lane (
        .size     (req_q.size),
        .offs     (req_q.addr[1:0]),
        .wdata    (wword_q[15:0]),
        .old_byte (rd_lanes[g]),
        .new_byte (mrg_lanes[g])
      );
    end
  endgenerate

  always_comb begin
    ld_byte = rd_lanes[~req_q.addr[1:0]];
    ld_half = req_q.addr[1] ? Mem_read_data[15:0] : Mem_read_data[31:16];
    case (req_q.size)
      SZ_B:    ld_data = {{24{req_q.sgn & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{req_q.sgn & ld_half[15]}}, ld_half};
      default: ld_data = Mem_read_data;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    resp_vld_nxt = 1'b0;
    resp_err_nxt = 1'b0;
    rdata_nxt    = '0;
    case (state)
      IDLE: if (accept) begin
        if (req_err) begin
          state_nxt    = RESP_ERR;
          resp_vld_nxt = 1'b1;
          resp_err_nxt = 1'b1;
        end else if (Req_write && Req_size == SZ_W) begin
          state_nxt = WR;
        end else begin
          state_nxt = RD;
        end
      end
      RD:        state_nxt = RD_DONE;
      RD_DONE: begin
        if (req_q.write) begin
          state_nxt = RMW_MERGE;
        end else begin
          state_nxt    = IDLE;
          resp_vld_nxt = 1'b1;
          rdata_nxt    = ld_data;
        end
      end
      RMW_MERGE: state_nxt = WR;
      WR: begin
        state_nxt    = IDLE;
        resp_vld_nxt = 1'b1;
      end
      RESP_ERR:  state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      req_q      <= '0;
      wword_q    <= '0;
      Resp_valid <= 1'b0;
      Resp_err   <= 1'b0;
      Resp_rdata <= '0;
    end else begin
      state      <= state_nxt;
      Resp_valid <= resp_vld_nxt;
      Resp_err   <= resp_err_nxt;
      if (resp_vld_nxt) Resp_rdata <= rdata_nxt;
      if (accept) begin
        req_q   <= '{write: Req_write, size: Req_size, sgn: Req_signed, addr: Req_addr};
        wword_q <= Req_wdata;
      end else if (state == RD_DONE && req_q.write) begin
        wword_q <= mrg_lanes;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: synchronous word memory, byte-level reference model,
// directed scenarios plus a randomized request stream.

module tb_mem_access_unit;
  localparam int MW = 1000;

  logic        Clk = 1'b0, Rst_n = 1'b0;
  logic        Req_valid = 1'b0, Req_write = 1'b0, Req_signed = 1'b0;
  logic [1:0]  Req_size = '0;
  logic [31:0] Req_addr = '0, Req_wdata = '0;
  logic        Req_ready, Resp_valid, Resp_err, Mem_read, Mem_write;
  logic [31:0] Resp_rdata, Mem_address, Mem_write_data;
  logic [31:0] Mem_read_data = '0;

  always #5 Clk = ~Clk;

  mem_access_unit #(.MEM_WORDS(MW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req_valid(Req_valid), .Req_ready(Req_ready),
    .Req_write(Req_write), .Req_size(Req_size), .Req_signed(Req_signed),
    .Req_addr(Req_addr), .Req_wdata(Req_wdata), .Resp_valid(Resp_valid),
    .Resp_rdata(Resp_rdata), .Resp_err(Resp_err), .Mem_address(Mem_address),
    .Mem_write_data(Mem_write_data), .Mem_read(Mem_read), .Mem_write(Mem_write),
    .Mem_read_data(Mem_read_data)
  );

  int checks = 0, errors = 0;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;

  // Memory seen by the DUT, plus a preload port driven by the bench
  logic [31:0] mem [MW];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] last_wr_addr = '0, last_wr_data = '0;

  always @(posedge Clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (Mem_write && Mem_address < MW) begin
      mem[Mem_address[9:0]] <= Mem_write_data;
      last_wr_addr <= Mem_address;
      last_wr_data <= Mem_write_data;
    end
    if (Mem_read && Mem_address < MW) Mem_read_data <= mem[Mem_address[9:0]];
  end

  always @(negedge Clk) begin
    if (Mem_read)  rd_cnt++;
    if (Mem_write) wr_cnt++;
    if (Mem_read && Mem_write) both_cnt++;
  end

  // Reference model: memory as an array of words, lanes picked by shifting
  logic [31:0] ref_mem [MW];

  function automatic void model(input bit wr, input logic [1:0] sz, input bit sg,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output bit er, output int lat);
    logic [31:0] w, v, mask;
    int idx, sh;
    rd = '0;
    er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || ((a >> 2) >= MW);
    if (er) begin lat = 1; return; end
    idx = int'(a >> 2);
    w   = ref_mem[idx];
    sh  = (sz == 2'd0) ? 8 * (3 - int'(a[1:0])) : (a[1] ? 0 : 16);
    mask = (sz == 2'd0) ? (32'hFF << sh) : (32'hFFFF << sh);
    if (!wr) begin
      lat = 3;
      if (sz == 2'd2) rd = w;
      else begin
        v = (w & mask) >> sh;
        if (sz == 2'd0 && sg && v[7])  v = v | 32'hFFFFFF00;
        if (sz == 2'd1 && sg && v[15]) v = v | 32'hFFFF0000;
        rd = v;
      end
    end else if (sz == 2'd2) begin
      lat = 2;
      ref_mem[idx] = wd;
    end else begin
      lat = 5;
      ref_mem[idx] = (w & ~mask) | ((wd << sh) & mask);
    end
  endfunction

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge Clk);
    pl_en = 1'b1; pl_idx = 10'(idx); pl_data = d;
    ref_mem[idx] = d;
    @(posedge Clk); #1 pl_en = 1'b0;
    @(negedge Clk);
  endtask

  // Issue one request from a negedge; returns observed and modelled results at the response negedge
  task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat, output bit busy_rdy,
                        output logic [31:0] e_rd, output bit e_er, output int e_lat);
    int w = 0;
    model(wr, sz, sg, a, wd, e_rd, e_er, e_lat);
    while (Req_ready !== 1'b1 && w < 20) begin @(negedge Clk); w++; end
    Req_write = wr; Req_size = sz; Req_signed = sg; Req_addr = a; Req_wdata = wd;
    Req_valid = 1'b1;
    @(posedge Clk); #1 Req_valid = 1'b0;
    lat = 0; busy_rdy = 1'b0; rd = '0; er = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk); lat++;
      if (Resp_valid === 1'b1) break;
      if (Req_ready === 1'b1) busy_rdy = 1'b1;
    end
    checks++;
    if (Resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_timeout addr=%h: Resp_valid=%b after %0d cycles, required 1", a, Resp_valid, lat);
    end else begin
      rd = Resp_rdata; er = Resp_err;
    end
  endtask

  task automatic test_reset();
    Req_valid = 1'b1;
    #3;
    checks += 9;
    if (Req_ready !== 1'b1)      begin errors++; $display("FAIL rst_ready got %b want 1", Req_ready); end
    if (Resp_valid !== 1'b0)     begin errors++; $display("FAIL rst_resp_valid got %b want 0", Resp_valid); end
    if (Resp_err !== 1'b0)       begin errors++; $display("FAIL rst_resp_err got %b want 0", Resp_err); end
    if (Resp_rdata !== 32'h0)    begin errors++; $display("FAIL rst_rdata got %h want 0", Resp_rdata); end
    if (Mem_read !== 1'b0)       begin errors++; $display("FAIL rst_mem_read got %b want 0", Mem_read); end
    if (Mem_write !== 1'b0)      begin errors++; $display("FAIL rst_mem_write got %b want 0", Mem_write); end
    if (Mem_address !== 32'h0)   begin errors++; $display("FAIL rst_mem_addr got %h want 0", Mem_address); end
    if (Mem_write_data !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got %h want 0", Mem_write_data); end
    @(posedge Clk); #1;
    if (Resp_valid !== 1'b0)     begin errors++; $display("FAIL rst_hold_valid got %b want 0", Resp_valid); end
    Req_valid = 1'b0;
    @(negedge Clk); Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_load_ext();
    logic [31:0] rd, e_rd; logic er; bit e_er, br; int lat, e_lat;
    preload(5, 32'h11223344);
    do_req(1'b0, 2'd0, 1'b1, 32'h15, 32'h0, rd, er, lat, br, e_rd, e_er, e_lat);
    checks += 3;
    if (rd !== 32'h00000022) begin errors++; $display("FAIL ld_byte_data got %h want 00000022", rd); end
    if (er !== 1'b0)         begin errors++; $display("FAIL ld_byte_err got %b want 0", er); end
    if (lat != 3)            begin errors++; $display("FAIL ld_byte_latency got %0d want 3", lat); end
    @(negedge Clk);
    checks += 2;
    if (Resp_valid !== 1'b0)      begin errors++; $display("FAIL resp_one_cycle got %b want 0", Resp_valid); end
    if (Resp_rdata !== 32'h22)    begin errors++; $display("FAIL rdata_hold got %h want 00000022", Resp_rdata); end
    preload(5, 32'h8899AABB);
    do_req(1'b0, 2'd1, 1'b1, 32'h14, 32'h0, rd, er, lat, br, e_rd, e_er, e_lat);
    checks++;
    if (rd !== 32'hFFFF8899) begin errors++; $display("FAIL ld_half_signed got %h want ffff8899", rd); end
    do_req(1'b0, 2'd1, 1'b0, 32'h14, 32'h0, rd, er, lat, br, e_rd, e_er, e_lat);
    checks++;
    if (rd !== 32'h00008899) begin errors++; $display("FAIL ld_half_unsigned got %h want 00008899", rd); end
    do_req(1'b0, 2'd0, 1'b1, 32'h16, 32'h0, rd, er, lat, br, e_rd, e_er, e_lat);
    checks++;
    if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL ld_byte_neg got %h want ffffffaa", rd); end
  endtask

  task automatic test_store_byte();
    logic [31:0] rd, e_rd; logic er; bit e_er, br; int lat, e_lat;
    preload(5, 32'h11223344);
    do_req(1'b1, 2'd0, 1'b0, 32'h17, 32'hEE, rd, er, lat, br, e_rd, e_er, e_lat);
    checks += 5;
    if (last_wr_data !== 32'h112233EE) begin errors++; $display("FAIL st_byte_wdata got %h want 112233ee", last_wr_data); end
    if (last_wr_addr !== 32'd5)        begin errors++; $display("FAIL st_byte_waddr got %h want 5", last_wr_addr); end
    if (rd !== 32'h0 || er !== 1'b0)   begin errors++; $display("FAIL st_byte_resp got %h/%b want 0/0", rd, er); end
    if (lat != 5)                      begin errors++; $display("FAIL st_byte_latency got %0d want 5", lat); end
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, rd, er, lat, br, e_rd, e_er, e_lat);
    if (rd !== 32'h112233EE)           begin errors++; $display("FAIL st_byte_readback got %h want 112233ee", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, e_rd; logic er; bit e_er, br; int lat, e_lat, r0, w0;
    logic [31:0] addrs [4];
    logic [1:0]  sizes [4];
    addrs = '{32'h16, 32'd4000, 32'h20, 32'h21};
    sizes = '{2'd2, 2'd2, 2'd3, 2'd1};
    for (int i = 0; i < 4; i++) begin
      r0 = rd_cnt; w0 = wr_cnt;
      do_req(1'b0, sizes[i], 1'b0, addrs[i], 32'h0, rd, er, lat, br, e_rd, e_er, e_lat);
      checks += 4;
      if (er !== 1'b1)   begin errors++; $display("FAIL err_flag[%0d] got %b want 1", i, er); end
      if (rd !== 32'h0)  begin errors++; $display("FAIL err_rdata[%0d] got %h want 0", i, rd); end
      if (lat != 1)      begin errors++; $display("FAIL err_latency[%0d] got %0d want 1", i, lat); end
      if (rd_cnt != r0 || wr_cnt != w0)
        begin errors++; $display("FAIL err_mem_access[%0d] got rd=%0d wr=%0d want 0", i, rd_cnt - r0, wr_cnt - w0); end
    end
  endtask

  task automatic test_reset_in_wr();
    int v0;
    preload(7, 32'hCAFE0007);
    Req_write = 1'b1; Req_size = 2'd2; Req_signed = 1'b0; Req_addr = 32'h1C; Req_wdata = 32'hDEADBEEF;
    Req_valid = 1'b1;
    @(posedge Clk); #1 Req_valid = 1'b0;
    checks++;
    if (Mem_write !== 1'b1) begin errors++; $display("FAIL rwr_in_wr got %b want 1", Mem_write); end
    #1 Rst_n = 1'b0;
    #1;
    checks += 3;
    if (Mem_write !== 1'b0)    begin errors++; $display("FAIL rwr_write_drop got %b want 0", Mem_write); end
    if (Req_ready !== 1'b1)    begin errors++; $display("FAIL rwr_ready got %b want 1", Req_ready); end
    if (Mem_address !== 32'h0) begin errors++; $display("FAIL rwr_addr got %h want 0", Mem_address); end
    @(posedge Clk);
    @(negedge Clk); Rst_n = 1'b1;
    v0 = 0;
    repeat (4) begin @(negedge Clk); if (Resp_valid === 1'b1) v0++; end
    checks += 2;
    if (v0 != 0)                  begin errors++; $display("FAIL rwr_no_resp got %0d pulses want 0", v0); end
    if (mem[7] !== ref_mem[7])    begin errors++; $display("FAIL rwr_mem got %h want %h", mem[7], ref_mem[7]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, e_rd; logic er; bit e_er, br0, br1; int lat, e_lat, b0;
    b0 = both_cnt;
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hA5A55A5A, rd, er, lat, br0, e_rd, e_er, e_lat);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, br1, e_rd, e_er, e_lat);
    checks += 4;
    if (rd !== 32'hA5A55A5A) begin errors++; $display("FAIL b2b_readback got %h want a5a55a5a", rd); end
    if (lat != 3)            begin errors++; $display("FAIL b2b_latency got %0d want 3", lat); end
    if (br0 || br1)          begin errors++; $display("FAIL b2b_ready_busy got %b%b want 00", br0, br1); end
    if (both_cnt != b0)      begin errors++; $display("FAIL b2b_rd_wr_overlap got %0d want 0", both_cnt - b0); end
  endtask

  task automatic test_random();
    logic [31:0] rd, e_rd, a, wd; logic er; bit e_er, br, wr, sg; int lat, e_lat, r;
    logic [1:0] sz;
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a  = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(MW * 4, MW * 4 + 400));
      wd = $urandom;
      do_req(wr, sz, sg, a, wd, rd, er, lat, br, e_rd, e_er, e_lat);
      checks++;
      if (rd !== e_rd || er !== e_er || lat != e_lat)
        begin errors++; $display("FAIL rand[%0d] wr=%b sz=%0d a=%h got %h/%b/%0d want %h/%b/%0d",
                                 n, wr, sz, a, rd, er, lat, e_rd, e_er, e_lat); end
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL rand_mem[%0d] got %h want %h", i, mem[i], ref_mem[i]); end
    end
    checks++;
    if (both_cnt != 0) begin errors++; $display("FAIL rd_wr_overlap got %0d want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    test_load_ext();
    test_store_byte();
    test_errors();
    test_reset_in_wr();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
